// File: rtl/light_solver_pkg.sv
// Shared definitions for the light/button toggle puzzle solver:
// default sizes, solver FSM states and the press-count width helper.
package light_solver_pkg;

  localparam int DEFAULT_MAX_BUTTON_COUNT = 13;
  localparam int DEFAULT_MACHINE_COUNT    = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } solver_state_e;

  // Bits needed to hold any count from 0 to max_buttons inclusive.
  function automatic int press_width(input int max_buttons);
    return $clog2(max_buttons + 1);
  endfunction

endpackage

// File: rtl/button_press_counter.sv
// Combinational popcount of a button-press combination.
module button_press_counter
  import light_solver_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_MAX_BUTTON_COUNT,
  parameter int COUNT_W = press_width(WIDTH)
) (
  input  logic [WIDTH-1:0]   combination,
  output logic [COUNT_W-1:0] presses
);

  always_comb begin
    presses = '0;
    for (int i = 0; i < WIDTH; i++) begin
      presses = presses + COUNT_W'(combination[i]);
    end
  end

endmodule

// File: rtl/light_target_combination_solver.sv
// Exhaustive solver: walks every button combination and keeps the one with the
// fewest presses whose XOR of button masks reproduces the target light pattern.
module light_target_combination_solver
  import light_solver_pkg::*;
#(
  parameter int MAX_BUTTON_COUNT = DEFAULT_MAX_BUTTON_COUNT,
  parameter int MACHINE_COUNT    = DEFAULT_MACHINE_COUNT,
  localparam int PRESS_W         = press_width(MAX_BUTTON_COUNT)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_valid,
  output logic                                  start_ready,
  input  logic [MACHINE_COUNT-1:0]              target_lights,
  input  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0] flattened_buttons,
  input  logic [PRESS_W-1:0]                    button_count,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic                                  result_found,
  output logic [MAX_BUTTON_COUNT-1:0]           result_combination,
  output logic [PRESS_W-1:0]                    result_presses
);

  // One spare counter bit so the final combination at full width cannot wrap.
  localparam int CNT_W = MAX_BUTTON_COUNT + 1;
  localparam logic [PRESS_W-1:0] BC_MAX = PRESS_W'(MAX_BUTTON_COUNT);

  solver_state_e state_q, state_d;
  logic [MACHINE_COUNT-1:0]                  target_q, target_d;
  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0] buttons_q, buttons_d;
  logic [PRESS_W-1:0]                        bc_q, bc_d;
  logic [CNT_W-1:0]                          counter_q, counter_d;
  logic                                      best_found_q, best_found_d;
  logic [MAX_BUTTON_COUNT-1:0]               best_comb_q, best_comb_d;
  logic [PRESS_W-1:0]                        best_presses_q, best_presses_d;

  logic [MACHINE_COUNT-1:0] eval_lights;
  logic [PRESS_W-1:0]       eval_presses;
  logic [CNT_W-1:0]         last_count;
  logic                     improves;

  button_press_counter #(
    .WIDTH  (MAX_BUTTON_COUNT),
    .COUNT_W(PRESS_W)
  ) u_press_counter (
    .combination(counter_q[MAX_BUTTON_COUNT-1:0]),
    .presses    (eval_presses)
  );

  always_comb begin
    eval_lights = '0;
    for (int j = 0; j < MAX_BUTTON_COUNT; j++) begin
      if (counter_q[j]) begin
        eval_lights = eval_lights ^ buttons_q[j*MACHINE_COUNT +: MACHINE_COUNT];
      end
    end
    last_count = (CNT_W'(1) << bc_q) - CNT_W'(1);
    // Strict less-than keeps the numerically earlier combination on ties.
    improves = (eval_lights == target_q) &&
               (!best_found_q || (eval_presses < best_presses_q));
  end

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    buttons_d      = buttons_q;
    bc_d           = bc_q;
    counter_d      = counter_q;
    best_found_d   = best_found_q;
    best_comb_d    = best_comb_q;
    best_presses_d = best_presses_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          target_d       = target_lights;
          buttons_d      = flattened_buttons;
          bc_d           = (button_count > BC_MAX) ? BC_MAX : button_count;
          counter_d      = '0;
          best_found_d   = 1'b0;
          best_comb_d    = '0;
          best_presses_d = '0;
          state_d        = SEARCH;
        end
      end
      SEARCH: begin
        if (improves) begin
          best_found_d   = 1'b1;
          best_comb_d    = counter_q[MAX_BUTTON_COUNT-1:0];
          best_presses_d = eval_presses;
        end
        if (counter_q == last_count) begin
          state_d = DONE;
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      target_q       <= '0;
      buttons_q      <= '0;
      bc_q           <= '0;
      counter_q      <= '0;
      best_found_q   <= 1'b0;
      best_comb_q    <= '0;
      best_presses_q <= '0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      buttons_q      <= buttons_d;
      bc_q           <= bc_d;
      counter_q      <= counter_d;
      best_found_q   <= best_found_d;
      best_comb_q    <= best_comb_d;
      best_presses_q <= best_presses_d;
    end
  end

  // Results are gated by DONE so nothing stale is visible while idle or searching.
  assign start_ready        = (state_q == IDLE) && !rst;
  assign result_valid       = (state_q == DONE);
  assign result_found       = result_valid && best_found_q;
  assign result_combination = result_found ? best_comb_q : '0;
  assign result_presses     = result_found ? best_presses_q : '0;

endmodule

// File: tb/tb_light_target_combination_solver.sv
// Randomised and directed bench for the light puzzle solver, checked against a
// brute-force "fewest presses first, lowest combination first" reference model.
module tb_light_target_combination_solver;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [9:0]   target_lights;
  logic [129:0] flattened_buttons;
  logic [3:0]   button_count;
  logic         result_valid;
  logic         result_ready;
  logic         result_found;
  logic [12:0]  result_combination;
  logic [3:0]   result_presses;

  int total = 0;
  int bad   = 0;

  logic [9:0] btn_arr [13];

  light_target_combination_solver dut (
    .clk               (clk),
    .rst               (rst),
    .start_valid       (start_valid),
    .start_ready       (start_ready),
    .target_lights     (target_lights),
    .flattened_buttons (flattened_buttons),
    .button_count      (button_count),
    .result_valid      (result_valid),
    .result_ready      (result_ready),
    .result_found      (result_found),
    .result_combination(result_combination),
    .result_presses    (result_presses)
  );

  always #5 clk = ~clk;

  function automatic logic [129:0] pack_buttons();
    logic [129:0] p;
    p = '0;
    for (int j = 0; j < 13; j++) p[j*10 +: 10] = btn_arr[j];
    return p;
  endfunction

  // Reference: try press counts 0,1,2,... and within each count the lowest
  // combination value first; the first hit is the required answer.
  task automatic ref_solve(input logic [9:0] tgt, input logic [3:0] bc,
                           output bit found, output logic [12:0] comb, output int presses);
    int eff;
    logic [9:0] lights;
    eff = (bc > 13) ? 13 : int'(bc);
    found = 0; comb = '0; presses = 0;
    for (int k = 0; k <= eff && !found; k++) begin
      for (int c = 0; c < (1 << eff) && !found; c++) begin
        if ($countones(c) == k) begin
          lights = '0;
          for (int j = 0; j < eff; j++) if (c[j]) lights = lights ^ btn_arr[j];
          if (lights == tgt) begin
            found = 1; comb = 13'(c); presses = k;
          end
        end
      end
    end
  endtask

  // Starts a solve (handshake edge = cycle 0), scrambles inputs while busy and
  // reports the cycle in which result_valid first appears.
  task automatic run_solve(input logic [9:0] tgt, input logic [3:0] bc,
                           output int lat, output bit timed_out);
    target_lights     = tgt;
    flattened_buttons = pack_buttons();
    button_count      = bc;
    start_valid       = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 0;
    timed_out = 1'b1;
    for (int k = 1; k <= 9000; k++) begin
      if (result_valid) begin
        lat = k; timed_out = 1'b0; break;
      end
      target_lights     = 10'($urandom);
      flattened_buttons = {$urandom, $urandom, $urandom, $urandom, $urandom};
      button_count      = 4'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic accept_result();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic set_example();
    foreach (btn_arr[j]) btn_arr[j] = 10'h3FF;
    btn_arr[0] = 10'h008; btn_arr[1] = 10'h00A; btn_arr[2] = 10'h004;
    btn_arr[3] = 10'h00C; btn_arr[4] = 10'h005; btn_arr[5] = 10'h003;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", result_valid); end
    total++; if (result_found !== 1'b0) begin bad++; $display("FAIL reset_found got=%b want=0", result_found); end
    total++; if (result_combination !== 13'h0) begin bad++; $display("FAIL reset_comb got=%h want=0", result_combination); end
    total++; if (result_presses !== 4'h0) begin bad++; $display("FAIL reset_presses got=%0d want=0", result_presses); end
    total++; if (start_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b want=0", start_ready); end
    rst = 1'b0;
    #1;
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", start_ready); end
  endtask

  task automatic test_example();
    int lat; bit to;
    set_example();
    run_solve(10'h006, 4'd6, lat, to);
    total++; if (to) begin bad++; $display("FAIL example_timeout got=none want=result_valid"); end
    total++; if (lat !== 65) begin bad++; $display("FAIL example_latency got=%0d want=65", lat); end
    total++; if (result_found !== 1'b1) begin bad++; $display("FAIL example_found got=%b want=1", result_found); end
    total++; if (result_combination !== 13'h00A) begin bad++; $display("FAIL example_comb got=%h want=00a", result_combination); end
    total++; if (result_presses !== 4'd2) begin bad++; $display("FAIL example_presses got=%0d want=2", result_presses); end
    accept_result();
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL example_ready_after got=%b want=1", start_ready); end
  endtask

  task automatic test_zero_target();
    int lat; bit to;
    foreach (btn_arr[j]) btn_arr[j] = 10'($urandom);
    run_solve(10'h000, 4'd4, lat, to);
    total++; if (to || lat !== 17) begin bad++; $display("FAIL zero_latency got=%0d want=17", lat); end
    total++; if (result_found !== 1'b1) begin bad++; $display("FAIL zero_found got=%b want=1", result_found); end
    total++; if (result_combination !== 13'h0) begin bad++; $display("FAIL zero_comb got=%h want=0", result_combination); end
    total++; if (result_presses !== 4'd0) begin bad++; $display("FAIL zero_presses got=%0d want=0", result_presses); end
    accept_result();
  endtask

  task automatic test_unreachable();
    int lat; bit to;
    foreach (btn_arr[j]) btn_arr[j] = 10'h002;
    btn_arr[0] = 10'h001;
    run_solve(10'h002, 4'd1, lat, to);
    total++; if (to || lat !== 3) begin bad++; $display("FAIL unreach_latency got=%0d want=3", lat); end
    total++; if (result_found !== 1'b0) begin bad++; $display("FAIL unreach_found got=%b want=0", result_found); end
    total++; if (result_combination !== 13'h0) begin bad++; $display("FAIL unreach_comb got=%h want=0", result_combination); end
    total++; if (result_presses !== 4'd0) begin bad++; $display("FAIL unreach_presses got=%0d want=0", result_presses); end
    accept_result();
  endtask

  task automatic test_full_width();
    int lat; bit to;
    foreach (btn_arr[j]) btn_arr[j] = 10'h001;
    btn_arr[12] = 10'h3FF;
    run_solve(10'h3FF, 4'd13, lat, to);
    total++; if (to || lat !== 8193) begin bad++; $display("FAIL full_latency got=%0d want=8193", lat); end
    total++; if (result_found !== 1'b1) begin bad++; $display("FAIL full_found got=%b want=1", result_found); end
    total++; if (result_combination !== 13'h1000) begin bad++; $display("FAIL full_comb got=%h want=1000", result_combination); end
    total++; if (result_presses !== 4'd1) begin bad++; $display("FAIL full_presses got=%0d want=1", result_presses); end
    accept_result();
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    set_example();
    run_solve(10'h006, 4'd6, lat, to);
    total++; if (to) begin bad++; $display("FAIL bp_timeout got=none want=result_valid"); end
    for (int c = 0; c < 5; c++) begin
      start_valid       = ~start_valid;
      target_lights     = 10'($urandom);
      flattened_buttons = {$urandom, $urandom, $urandom, $urandom, $urandom};
      button_count      = 4'($urandom);
      @(posedge clk); #1;
      total++; if (result_valid !== 1'b1 || result_found !== 1'b1 || result_combination !== 13'h00A || result_presses !== 4'd2)
        begin bad++; $display("FAIL bp_hold c=%0d got=%b/%b/%h/%0d want=1/1/00a/2", c, result_valid, result_found, result_combination, result_presses); end
      total++; if (start_ready !== 1'b0) begin bad++; $display("FAIL bp_start_ready c=%0d got=%b want=0", c, start_ready); end
    end
    start_valid = 1'b0;
    accept_result();
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b want=1", start_ready); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_after got=%b want=0", result_valid); end
  endtask

  task automatic test_reset_mid_search();
    int lat; bit to;
    set_example();
    target_lights = 10'h006; flattened_buttons = pack_buttons(); button_count = 4'd6;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", result_valid); end
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", start_ready); end
    total++; if (result_found !== 1'b0) begin bad++; $display("FAIL midrst_found got=%b want=0", result_found); end
    run_solve(10'h006, 4'd6, lat, to);
    total++; if (to || lat !== 65 || result_combination !== 13'h00A || result_presses !== 4'd2 || result_found !== 1'b1)
      begin bad++; $display("FAIL midrst_rerun got=lat%0d/%b/%h/%0d want=lat65/1/00a/2", lat, result_found, result_combination, result_presses); end
    accept_result();
  endtask

  task automatic test_random();
    int lat, exp_presses, eff; bit to, exp_found;
    logic [12:0] exp_comb; logic [9:0] tgt; logic [3:0] bc;
    for (int it = 0; it < 10; it++) begin
      bc = (it == 0 || it == 1) ? 4'd0 : (it == 2) ? 4'd15 : 4'($urandom_range(1, 7));
      eff = (bc > 13) ? 13 : int'(bc);
      foreach (btn_arr[j]) btn_arr[j] = 10'($urandom_range(1, 1023));
      if (it == 0) tgt = 10'h000;
      else if (it == 1 || $urandom_range(0, 2) == 0) tgt = 10'($urandom_range(1, 1023));
      else begin
        tgt = '0;
        for (int j = 0; j < eff; j++) if ($urandom_range(0, 1) == 1) tgt = tgt ^ btn_arr[j];
      end
      ref_solve(tgt, bc, exp_found, exp_comb, exp_presses);
      run_solve(tgt, bc, lat, to);
      total++; if (to || lat !== (1 << eff) + 1) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", it, lat, (1 << eff) + 1); end
      total++; if (result_found !== exp_found) begin bad++; $display("FAIL rand%0d_found got=%b want=%b", it, result_found, exp_found); end
      total++; if (result_combination !== exp_comb) begin bad++; $display("FAIL rand%0d_comb got=%h want=%h", it, result_combination, exp_comb); end
      total++; if (int'(result_presses) !== exp_presses) begin bad++; $display("FAIL rand%0d_presses got=%0d want=%0d", it, result_presses, exp_presses); end
      accept_result();
      total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL rand%0d_ready_after got=%b want=1", it, start_ready); end
    end
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
    target_lights = '0; flattened_buttons = '0; button_count = '0;
    foreach (btn_arr[j]) btn_arr[j] = '0;
    test_reset();
    test_example();
    test_zero_target();
    test_unreachable();
    test_full_width();
    test_backpressure();
    test_reset_mid_search();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/light_target_combination_solver.md
# light_target_combination_solver

Sequential solver for the light/button toggle puzzle. Given a target light pattern and the per-button light masks, it enumerates every button combination and returns the combination with the fewest presses whose XOR of button masks equals the target. It is the inverse of the combinational "combination → light pattern" evaluation and sits between the puzzle-input loader and the per-machine press accumulator.

## Interface
- `MAX_BUTTON_COUNT`, 13: maximum buttons per machine.
- `MACHINE_COUNT`, 10: number of lights per machine.
- `PRESS_W`, derived `$clog2(MAX_BUTTON_COUNT+1)`: width of counts.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start_valid` in 1: request a solve.
- `start_ready` out 1: solver idle and can accept a request.
- `target_lights` in `MACHINE_COUNT`: required light pattern, bit i = light i on.
- `flattened_buttons` in `MACHINE_COUNT*MAX_BUTTON_COUNT`: bit `j*MACHINE_COUNT+i` = button j toggles light i.
- `button_count` in `PRESS_W`: number of valid buttons, which are buttons 0..button_count-1.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.
- `result_found` out 1: a matching combination exists.
- `result_combination` out `MAX_BUTTON_COUNT`: bit j = press button j.
- `result_presses` out `PRESS_W`: popcount of `result_combination`.

## Operation
- FSM states: IDLE, SEARCH, DONE.
- `start_ready = (state==IDLE) && !rst`.
- **IDLE, on `start_valid && start_ready`:**
  - latch target, buttons, and `button_count` (clamped to `MAX_BUTTON_COUNT`);
  - set combination counter (`MAX_BUTTON_COUNT+1` bits) to 0 and `best_found` to 0;
  - go to SEARCH.
- **SEARCH, each cycle:**
  - compute the XOR of the latched masks selected by the counter;
  - on a match with `!best_found || popcount < best_presses`, store counter, popcount, and set `best_found`;
  - ties keep the earlier (numerically lower) combination; comparison is strict less-than.
  - If counter == (1 << bc) − 1, go to DONE; otherwise increment the counter. The extra counter bit prevents wrap at bc = `MAX_BUTTON_COUNT`.
- **DONE:**
  - `result_*` is driven from the best registers and held stable while `result_valid && !result_ready`;
  - on the handshake, go to IDLE.
- Not found: `result_found`=0, `result_combination`=0, `result_presses`=0.
- bc = 0: exactly one SEARCH cycle evaluates combination 0. It matches only if target == 0.
- Ports other than handshakes are ignored outside the start handshake; changes during SEARCH/DONE have no effect.
- Buttons j ≥ bc never appear set in any evaluated combination.

## Timing
- Reset, effective at the next edge:
  - state IDLE;
  - `result_valid`=0, `result_found`=0, `result_combination`=0, `result_presses`=0;
  - `start_ready`=1 in the first cycle with `rst` low.
- Start handshake at edge 0 → SEARCH occupies cycles 1..2^bc → `result_valid`=1 from cycle 2^bc+1.
- Total latency is 2^bc+1 cycles, with no early termination.
- Result handshake at edge N → `start_ready`=1 in cycle N+1. Start and result handshakes never coincide.
- Reset mid-SEARCH or mid-DONE aborts: the next cycle is IDLE with outputs at reset values, and no partial result is emitted.

## Structure
- Shared package `light_solver_pkg`:
  - state enum (IDLE/SEARCH/DONE);
  - `PRESS_W` helper function.
- Sub-module `button_press_counter`: combinational popcount of `MAX_BUTTON_COUNT` bits to `PRESS_W` bits.
- The masked-XOR evaluation is inline in the solver.

## Test plan
- **Example machine.**
  - Inputs: target=0x006; buttons b0=0x008, b1=0x00A, b2=0x004, b3=0x00C, b4=0x005, b5=0x003; bc=6.
  - Required: found=1, combination=0x00A, presses=2 (beats 0x030 on tie), `result_valid` in cycle 65.
- **Zero target.** target=0, bc=4, arbitrary masks → found=1, combination=0, presses=0, `result_valid` in cycle 17.
- **Unreachable.** bc=1, b0=0x001, target=0x002 → found=0, combination=0, presses=0, `result_valid` in cycle 3.
- **Full width.** bc=13, b12=0x3FF, others 0x001, target=0x3FF.
  - Required: found=1, combination=0x1000, presses=1, `result_valid` in cycle 8193.
  - The counter must not wrap.
- **Backpressure.** Hold `result_ready`=0 for 5 cycles in DONE while toggling `start_valid` and the inputs.
  - Required: outputs stable, `start_ready`=0, no second start accepted.
  - After the handshake, `start_ready`=1 the next cycle.
- **Reset mid-search.** Assert `rst` in SEARCH cycle 10 of the example machine.
  - Required: next cycle `result_valid`=0 and `start_ready`=1.
  - A fresh start then reproduces the example result exactly.
